// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered ripple-carry full adder:
// the maximum supported operand width and the 1-bit full-adder cell equation.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // One full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s     = a ^ b ^ c;
    co    = (a & b) | (c & (a ^ b));
    fa_bit = {co, s};
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder_core.
// Optional macro FULL_ADDER_OVF_EN adds the registered signed-overflow flag ovf.
interface full_adder_if #(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;
`endif

  // Operand source side.
  modport master (
    output in_valid, a_in, b_in, c_in,
    input  sum, carry, out_valid
`ifdef FULL_ADDER_OVF_EN
    , input ovf
`endif
  );

  // Adder side.
  modport slave (
    input  in_valid, a_in, b_in, c_in,
    output sum, carry, out_valid
`ifdef FULL_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/full_adder_bit.sv
// Single full-adder cell, one link of the ripple-carry chain.
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic [1:0] res;

  assign res = fa_bit(a, b, c);
  assign s   = res[0];
  assign co  = res[1];

endmodule

// File: rtl/full_adder_core.sv
// Registered ripple-carry adder: {carry, sum} = a_in + b_in + c_in, one cycle
// after the operands are accepted. Results load only on in_valid, so idle
// (possibly unknown) operands never reach the output registers.
// Optional macro FULL_ADDER_OVF_EN adds the registered two's-complement
// overflow flag ovf = c_WIDTH ^ c_{WIDTH-1}.
module full_adder_core
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  full_adder_if.slave bus
);

  if ((WIDTH < 1) || (WIDTH > FA_MAX_WIDTH)) begin : g_width_check
    $error("full_adder_core: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   c_p0;
  logic [WIDTH-1:0] s_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             carry_p1;
  logic             vld_p1;

  assign c_p0[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_bit u_bit (
      .a  (bus.a_in[i]),
      .b  (bus.b_in[i]),
      .c  (c_p0[i]),
      .s  (s_p0[i]),
      .co (c_p0[i+1])
    );
  end

  // Result registers: capture the ripple result only on accepted operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1   <= '0;
      carry_p1 <= 1'b0;
    end else if (bus.in_valid) begin
      sum_p1   <= s_p0;
      carry_p1 <= c_p0[WIDTH];
    end
  end

  // Valid register: one output cycle per accepted operand set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
    end
  end

  assign bus.sum       = sum_p1;
  assign bus.carry     = carry_p1;
  assign bus.out_valid = vld_p1;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_p1;

  // Overflow register: signed overflow is the XOR of the top two carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p1 <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_p1 <= c_p0[WIDTH] ^ c_p0[WIDTH-1];
    end
  end

  assign bus.ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Scoreboard bench for full_adder_core at WIDTH = 1 and WIDTH = 8.
// Stimulus pushes hand-computed expectations; per-DUT monitors pop and compare
// whenever out_valid is seen.
module tb_full_adder_core;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder_core #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  full_adder_core #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct packed {
    logic [8:0] res;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // W1 monitor
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && bus1.out_valid) begin
      if (q1.size() == 0) begin
        check("w1_unexpected_valid", 16'd1, 16'd0);
      end else begin
        e = q1.pop_front();
        check("w1_carry_sum", {14'b0, bus1.carry, bus1.sum}, {7'b0, e.res});
`ifdef FULL_ADDER_OVF_EN
        check("w1_ovf", {15'b0, bus1.ovf}, {15'b0, e.ovf});
`endif
      end
    end
  end

  // W8 monitor
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && bus8.out_valid) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_valid", 16'd1, 16'd0);
      end else begin
        e = q8.pop_front();
        check("w8_carry_sum", {7'b0, bus8.carry, bus8.sum}, {7'b0, e.res});
`ifdef FULL_ADDER_OVF_EN
        check("w8_ovf", {15'b0, bus8.ovf}, {15'b0, e.ovf});
`endif
      end
    end
  end

  task automatic drive1(input logic v, input logic a, input logic b, input logic c,
                        input logic [1:0] exp_cs);
    exp_t e;
    @(posedge clk);
    #1;
    bus1.in_valid = v;
    bus1.a_in     = a;
    bus1.b_in     = b;
    bus1.c_in     = c;
    if (v) begin
      e.res = {7'b0, exp_cs};
      e.ovf = exp_cs[1] ^ c;
      q1.push_back(e);
    end
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] exp_cs, input logic exp_ovf);
    exp_t e;
    @(posedge clk);
    #1;
    bus8.in_valid = v;
    bus8.a_in     = a;
    bus8.b_in     = b;
    bus8.c_in     = c;
    if (v) begin
      e.res = exp_cs;
      e.ovf = exp_ovf;
      q8.push_back(e);
    end
  endtask

  // {a, b, c, carry, sum}
  logic [4:0] tab1 [8] = '{5'b000_00, 5'b100_01, 5'b110_10, 5'b111_11,
                           5'b101_10, 5'b010_01, 5'b011_10, 5'b001_01};

  // {a, b, c, {carry,sum}, ovf}
  logic [26:0] tab8 [7] = '{
    {8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0},
    {8'h0F, 8'h01, 1'b0, 9'h010, 1'b0},
    {8'h7F, 8'h01, 1'b0, 9'h080, 1'b1},
    {8'h80, 8'hFF, 1'b0, 9'h17F, 1'b1},
    {8'h01, 8'h01, 1'b0, 9'h002, 1'b0},
    {8'h00, 8'h00, 1'b0, 9'h000, 1'b0},
    {8'h55, 8'hAA, 1'b1, 9'h100, 1'b0}
  };

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rr;
    logic       a1, b1, c1;
    logic [1:0] r1;
    exp_t       dummy;

    bus1.in_valid = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.c_in = 1'b0;
    bus8.in_valid = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.c_in = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_w1_carry_sum", {14'b0, bus1.carry, bus1.sum}, 16'h0);
    check("rst_w1_out_valid", {15'b0, bus1.out_valid}, 16'h0);
    check("rst_w8_carry_sum", {7'b0, bus8.carry, bus8.sum}, 16'h0);
    check("rst_w8_out_valid", {15'b0, bus8.out_valid}, 16'h0);
`ifdef FULL_ADDER_OVF_EN
    check("rst_w8_ovf", {15'b0, bus8.ovf}, 16'h0);
`endif
    rst_n = 1'b1;

    // Exhaustive 1-bit table
    for (int i = 0; i < 8; i++) begin
      dummy.res = {4'b0, tab1[i]};
      drive1(1'b1, dummy.res[4], dummy.res[3], dummy.res[2], dummy.res[1:0]);
    end

    // Hold: load 1+1+0, then go idle with zero and then unknown operands
    drive1(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    check("hold_carry_sum", {14'b0, bus1.carry, bus1.sum}, 16'h2);
    check("hold_out_valid", {15'b0, bus1.out_valid}, 16'h0);
    bus1.a_in = 'x; bus1.b_in = 'x; bus1.c_in = 1'bx;
    @(posedge clk);
    #1;
    check("hold_x_carry_sum", {14'b0, bus1.carry, bus1.sum}, 16'h2);

    // Reset mid-stream: discard the in-flight 1+1+1 result
    drive1(1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    check("midrst_carry_sum", {14'b0, bus1.carry, bus1.sum}, 16'h0);
    check("midrst_out_valid", {15'b0, bus1.out_valid}, 16'h0);
    rst_n = 1'b1;
    bus1.a_in = 1'b0; bus1.b_in = 1'b1; bus1.c_in = 1'b1;
    dummy.res = 9'b0_0000_0010;
    dummy.ovf = 1'b0;
    q1.push_back(dummy);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Back-to-back 1-bit random vectors
    for (int i = 0; i < 20; i++) begin
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      c1 = 1'($urandom_range(0, 1));
      r1 = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
      drive1(1'b1, a1, b1, c1, r1);
    end
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // 8-bit directed vectors
    for (int i = 0; i < 7; i++) begin
      drive8(1'b1, tab8[i][26:19], tab8[i][18:11], tab8[i][10], tab8[i][9:1], tab8[i][0]);
    end

    // 8-bit back-to-back random vectors against an arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rr = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      drive8(1'b1, ra, rb, rc, rr, (ra[7] == rb[7]) && (rr[7] != ra[7]));
    end
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("w1_queue_drained", 16'(q1.size()), 16'h0);
    check("w8_queue_drained", 16'(q8.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
